// File: rtl/sha256_mem_host.sv
// sha256_mem_host
//   Memory-side responder and host controller for the SHA-256 engine.
//   It owns a word-addressed RAM and serves the engine memory port with
//   1-cycle registered reads (read-before-write). It loads MSG_WORDS
//   message words from the host stream, pulses eng_start, waits for the
//   engine to finish under a timeout, then streams the 8 hash words back
//   to the host.
// Ports
//   clk, reset_n           clock, async active-low reset
//   in_valid/in_ready/in_data               host message stream (32b)
//   out_valid/out_ready/out_data/out_last   hash stream, H0 first, last=H7
//   busy                   not IDLE
//   err_timeout, err_addr  sticky, cleared by the first word of a new run
//   eng_start              one-cycle start pulse
//   eng_done               engine idle/done
//   eng_message_addr, eng_output_addr   constant MSG_ADDR / OUT_ADDR
//   eng_mem_we/addr/write_data/read_data  engine memory port
module sha256_mem_host #(
  parameter int          DEPTH          = 256,
  parameter int          MSG_WORDS      = 20,
  parameter logic [15:0] MSG_ADDR       = 16'h0000,
  parameter logic [15:0] OUT_ADDR       = 16'h0080,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_addr,
  output logic        eng_start,
  input  logic        eng_done,
  output logic [15:0] eng_message_addr,
  output logic [15:0] eng_output_addr,
  input  logic        eng_mem_we,
  input  logic [15:0] eng_mem_addr,
  input  logic [31:0] eng_mem_write_data,
  output logic [31:0] eng_mem_read_data
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_L  = 17'(DEPTH);
  localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] LAST_CNT = 16'(MSG_WORDS - 1);

  // Elaboration-time parameter sanity.
  if (DEPTH < 8 || DEPTH > 65536 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two in 8..65536");
  end
  if (int'(MSG_ADDR) + MSG_WORDS > DEPTH) begin : g_bad_msg
    $error("message region exceeds DEPTH");
  end
  if (int'(OUT_ADDR) + 8 > DEPTH) begin : g_bad_out
    $error("output region exceeds DEPTH");
  end
  if (MSG_WORDS < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("MSG_WORDS must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_LO, S_WAIT_HI, S_DUMP
  } state_t;

  state_t          state, nxt;
  logic [15:0]     cnt;
  logic [2:0]      k;
  logic [TW-1:0]   tmr;
  logic            in_ready_d;

  logic            in_hs, out_hs, eng_own, eng_ok, tmo, abort, dump_go;
  logic [2:0]      k_rd;
  logic            we;
  logic [AW-1:0]   waddr, raddr, haddr;
  logic [31:0]     wdata;

  logic [31:0]     mem [DEPTH];

  assign eng_message_addr = MSG_ADDR;
  assign eng_output_addr  = OUT_ADDR;

  assign in_hs   = in_valid && in_ready;
  assign out_hs  = out_valid && out_ready;
  assign eng_own = (state == S_WAIT_LO) || (state == S_WAIT_HI);
  assign eng_ok  = {1'b0, eng_mem_addr} < DEPTH_L;
  assign tmo     = (tmr == TMO_LAST);
  // Done wins over timeout when both land in the same WAIT_HI cycle.
  assign abort   = (state == S_WAIT_LO && tmo) ||
                   (state == S_WAIT_HI && tmo && !eng_done);
  assign dump_go = (state == S_WAIT_HI) && eng_done;

  // Regions are range-checked at elaboration, so AW-bit sums cannot alias.
  assign haddr = MSG_ADDR[AW-1:0] + ((state == S_IDLE) ? AW'(0) : cnt[AW-1:0]);
  // Output read runs one word ahead: word 0 on entry, k+1 on a handshake.
  assign k_rd  = (state == S_DUMP) ? k + 3'd1 : 3'd0;
  assign raddr = OUT_ADDR[AW-1:0] + AW'(k_rd);

  // Single write port: engine in WAIT states, host stream otherwise.
  always_comb begin
    we    = 1'b0;
    waddr = haddr;
    wdata = in_data;
    if (eng_own) begin
      we    = eng_mem_we && eng_ok;
      waddr = eng_mem_addr[AW-1:0];
      wdata = eng_mem_write_data;
    end else begin
      we    = in_hs;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nxt;
  end

  // FSM: next state
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:    if (in_hs) nxt = (MSG_WORDS == 1) ? S_START : S_LOAD;
      S_LOAD:    if (in_hs && cnt == LAST_CNT) nxt = S_START;
      S_START:   nxt = S_WAIT_LO;
      S_WAIT_LO: if (abort) nxt = S_IDLE;
                 else if (!eng_done) nxt = S_WAIT_HI;
      S_WAIT_HI: if (dump_go) nxt = S_DUMP;
                 else if (abort) nxt = S_IDLE;
      S_DUMP:    if (out_hs && k == 3'd7) nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // FSM: outputs. in_ready is registered from the next state so it is low
  // in reset and drops the cycle after the last message word.
  always_comb begin
    in_ready_d = (nxt == S_IDLE) || (nxt == S_LOAD);
    eng_start  = (state == S_START);
    busy       = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready          <= 1'b0;
      cnt               <= '0;
      k                 <= '0;
      tmr               <= '0;
      err_timeout       <= 1'b0;
      err_addr          <= 1'b0;
      eng_mem_read_data <= '0;
      out_valid         <= 1'b0;
      out_last          <= 1'b0;
      out_data          <= '0;
    end else begin
      in_ready <= in_ready_d;

      if (in_hs) cnt <= (state == S_IDLE) ? 16'd1 : cnt + 16'd1;

      if (state == S_START) tmr <= '0;
      else if (eng_own)     tmr <= tmr + TW'(1);

      if (in_hs && state == S_IDLE) err_timeout <= 1'b0;
      else if (abort)               err_timeout <= 1'b1;

      if (in_hs && state == S_IDLE)  err_addr <= 1'b0;
      else if (eng_own && !eng_ok)   err_addr <= 1'b1;

      // Registered engine read; old data on same-address write.
      if (eng_own) eng_mem_read_data <= eng_ok ? mem[eng_mem_addr[AW-1:0]] : 32'h0;

      if (dump_go) begin
        out_valid <= 1'b1;
        out_last  <= 1'b0;
        k         <= 3'd0;
        out_data  <= mem[raddr];
      end else if (state == S_DUMP && out_hs) begin
        if (k == 3'd7) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          k        <= k + 3'd1;
          out_last <= (k == 3'd6);
          out_data <= mem[raddr];
        end
      end
    end
  end

endmodule

// File: tb/tb_sha256_mem_host.sv
// Randomized scoreboard bench for sha256_mem_host. A behavioural engine
// stub reads the message through the memory port, writes 8 result words
// computed by ref_h, and the monitor checks the host output stream
// against expectations pushed when each run is launched.
module tb_sha256_mem_host;
  localparam int          DEPTH = 256;
  localparam int          MSGW  = 20;
  localparam int          TMO   = 64;
  localparam logic [15:0] MSG_A = 16'h0000;
  localparam logic [15:0] OUT_A = 16'h0080;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic        busy, err_timeout, err_addr, eng_start, eng_done;
  logic [15:0] eng_message_addr, eng_output_addr, eng_mem_addr;
  logic        eng_mem_we;
  logic [31:0] eng_mem_write_data, eng_mem_read_data;

  sha256_mem_host #(
    .DEPTH(DEPTH), .MSG_WORDS(MSGW), .MSG_ADDR(MSG_A),
    .OUT_ADDR(OUT_A), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .err_timeout(err_timeout),
    .err_addr(err_addr), .eng_start(eng_start), .eng_done(eng_done),
    .eng_message_addr(eng_message_addr), .eng_output_addr(eng_output_addr),
    .eng_mem_we(eng_mem_we), .eng_mem_addr(eng_mem_addr),
    .eng_mem_write_data(eng_mem_write_data),
    .eng_mem_read_data(eng_mem_read_data)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed { logic [31:0] data; logic last; } exp_t;
  exp_t        exp_q[$];
  int          total = 0, bad = 0, vc_total = 0;
  bit          det_mode = 0;
  logic [31:0] msg [MSGW];
  logic [31:0] got [MSGW];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    total++; bad++;
    $display("FAIL %s", nm);
  endtask

  // Reference "engine" result: word k of the hash block for a message.
  function automatic logic [31:0] ref_h(input logic [31:0] m [MSGW], input int k);
    logic [31:0] acc;
    acc = 32'h6a09e667 ^ 32'(k);
    for (int i = 0; i < MSGW; i++)
      acc = {acc[26:0], acc[31:27]} + (m[i] ^ (32'h9e3779b9 * 32'(k + 1)));
    return acc;
  endfunction

  // out_ready driver: random, or a fixed 3-cycle stall on word 2.
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (det_mode) begin
        if (out_valid && exp_q.size() == 6 && stall_cnt < 3) begin
          out_ready = 1'b0; stall_cnt++;
        end else out_ready = 1'b1;
      end else begin
        stall_cnt = 0;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Output monitor / scoreboard.
  initial begin
    logic [31:0] pd;
    logic        pl;
    bit          ps;
    exp_t        e;
    ps = 0; pd = '0; pl = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) ps = 0;
      else begin
        if (out_valid) vc_total++;
        if (ps) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", out_data, pd);
          chk("hold_last", 32'(out_last), 32'(pl));
        end
        ps = out_valid && !out_ready; pd = out_data; pl = out_last;
        if (out_valid && exp_q.size() == 0) flag("unexpected_out_valid");
        else if (out_valid && out_ready) begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_last", 32'(out_last), 32'(e.last));
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d);
    int g;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; g = 0;
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    if (!in_ready) flag("in_ready_wait");
    @(posedge clk);
  endtask

  task automatic load_run(input bit gaps, input bit chk_clr);
    for (int i = 0; i < MSGW; i++) begin
      if (gaps && i > 0 && i % 3 == 0) begin
        @(negedge clk); in_valid = 1'b0; @(negedge clk);
      end
      send_word(msg[i]);
      if (i == 0 && chk_clr) begin
        @(negedge clk); in_valid = 1'b0;
        chk("err_timeout_clr", 32'(err_timeout), 32'd0);
        chk("err_addr_clr", 32'(err_addr), 32'd0);
      end
    end
    @(negedge clk); in_valid = 1'b0;
    chk("eng_start_pulse", 32'(eng_start), 32'd1);
    chk("in_ready_low_start", 32'(in_ready), 32'd0);
    chk("busy_start", 32'(busy), 32'd1);
    @(negedge clk);
    chk("eng_start_once", 32'(eng_start), 32'd0);
  endtask

  task automatic engine(input bit bad_a, input bit rbw);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    eng_done = 1'b0;
    if (bad_a) begin
      eng_mem_we = 1'b1; eng_mem_addr = 16'h0100; eng_mem_write_data = 32'hdeadbeef;
      @(negedge clk);
      eng_mem_we = 1'b0;
      chk("oob_read_zero", eng_mem_read_data, 32'h0);
    end
    for (int i = 0; i < MSGW; i++) begin
      eng_mem_addr = MSG_A + 16'(i);
      @(negedge clk);
      got[i] = eng_mem_read_data;
      chk("eng_read", got[i], msg[i]);
    end
    if (rbw) begin
      eng_mem_addr = MSG_A + 16'd5; eng_mem_we = 1'b1; eng_mem_write_data = ~msg[5];
      @(negedge clk);
      eng_mem_we = 1'b0;
      chk("rbw_old", eng_mem_read_data, msg[5]);
      @(negedge clk);
      chk("rbw_new", eng_mem_read_data, ~msg[5]);
    end
    for (int k = 0; k < 8; k++) begin
      eng_mem_we = 1'b1; eng_mem_addr = OUT_A + 16'(k); eng_mem_write_data = ref_h(got, k);
      @(negedge clk);
    end
    eng_mem_we = 1'b0; eng_mem_addr = 16'h0; eng_done = 1'b1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 300) begin
      @(negedge clk); g++;
      if (exp_q.size() > 1) chk("in_ready_low_busy", 32'(in_ready), 32'd0);
    end
    if (exp_q.size() > 0) begin flag("drain_timeout"); exp_q.delete(); end
    @(negedge clk);
    chk("in_ready_after", 32'(in_ready), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    chk("out_valid_after", 32'(out_valid), 32'd0);
  endtask

  task automatic full_run(input bit gaps, input bit bad_a, input bit rbw, input bit chk_clr);
    load_run(gaps, chk_clr);
    for (int k = 0; k < 8; k++) exp_q.push_back('{data: ref_h(msg, k), last: (k == 7)});
    engine(bad_a, rbw);
    drain();
  endtask

  task automatic rand_msg();
    for (int i = 0; i < MSGW; i++) msg[i] = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vc0;
    reset_n = 1'b0; in_valid = 1'b1; in_data = 32'hffffffff;
    eng_done = 1'b1; eng_mem_we = 1'b0; eng_mem_addr = 16'h0; eng_mem_write_data = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_eng_start", 32'(eng_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    chk("rst_err_addr", 32'(err_addr), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_eng_rd", eng_mem_read_data, 32'h0);
    in_valid = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("eng_message_addr", 32'(eng_message_addr), 32'(MSG_A));
    chk("eng_output_addr", 32'(eng_output_addr), 32'(OUT_A));

    // Deterministic "abc" message, gapped input, stall on word 2.
    for (int i = 0; i < MSGW; i++) msg[i] = 32'h61626300 + 32'(i);
    det_mode = 1; vc0 = vc_total;
    full_run(1'b1, 1'b0, 1'b1, 1'b0);
    chk("dump_cycles", 32'(vc_total - vc0), 32'd11);
    det_mode = 0;

    // Random runs; one with an out-of-range engine write, next clears it.
    for (int r = 0; r < 6; r++) begin
      rand_msg();
      full_run(1'($urandom_range(0, 1)), r == 2, 1'b0, r == 3);
      if (r == 2) chk("err_addr_set", 32'(err_addr), 32'd1);
    end

    // Timeout: engine never leaves idle-low.
    rand_msg();
    load_run(1'b0, 1'b0);
    eng_done = 1'b0;
    for (int c = 2; c <= TMO + 1; c++) begin
      @(negedge clk);
      if (c == TMO - 1) begin
        chk("tmo_not_yet", 32'(err_timeout), 32'd0);
        chk("tmo_busy", 32'(busy), 32'd1);
      end
      if (c == TMO + 1) begin
        chk("tmo_set", 32'(err_timeout), 32'd1);
        chk("tmo_idle", 32'(busy), 32'd0);
      end
    end
    eng_done = 1'b1;
    rand_msg();
    full_run(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset after 7 words; next load must start over at MSG_ADDR.
    rand_msg();
    for (int i = 0; i < 7; i++) send_word(msg[i]);
    @(negedge clk); in_valid = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_back", 32'(in_ready), 32'd1);
    rand_msg();
    full_run(1'b1, 1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
